sync_event_arbiter: RTL and testbench

Collects rising-edge events from `N_CH` asynchronous input lines and serialises them onto one valid/ready event stream tagged with the source channel index. Each line passes through the existing `bit_sync` 2-flop synchroniser, then an edge detector and a per-channel pending latch. A round-robin arbiter shares the single output port fairly between channels. The block sits between off-chip or foreign-domain status/interrupt lines and the consuming control logic.

---
 rtl/sync_evt_pkg.sv | 10 +
 rtl/bit_sync.sv | 25 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/sync_event_arbiter.sv | 137 +++++++++++++
 tb/tb_sync_event_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_evt_pkg.sv
// Shared types for the synchronised event arbiter.
// Holds the offer FSM state encoding.
package sync_evt_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous line.
// Synchronous active-low reset clears both stages.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// ptr is assumed to be in range 0..N_CH-1.
module rr_arbiter #(
  parameter int N_CH = 4,
  localparam int IDW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  sel,
  output logic            any
);

  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      logic [IDW-1:0] idx_b;
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_b = IDW'(idx);
      if (!any && req[idx_b]) begin
        any = 1'b1;
        sel = idx_b;
      end
    end
  end

endmodule

// File: rtl/sync_event_arbiter.sv
// Synchronises N_CH async event lines, latches rising edges per channel and
// serialises them onto one valid/ready stream with round-robin fairness.
module sync_event_arbiter
  import sync_evt_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int IDW = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] async_in,
  input  logic [N_CH-1:0] en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDW-1:0]  evt_id,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  logic            w_rst_n;
  logic [N_CH-1:0] w_s;
  logic [N_CH-1:0] r_s_d;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] w_pending_d;
  logic [N_CH-1:0] r_ovf;
  logic [N_CH-1:0] w_ovf_d;
  logic [N_CH-1:0] w_id_mask;
  logic [N_CH-1:0] w_clr;
  logic [N_CH-1:0] w_offered;
  logic [N_CH-1:0] w_arb_req;
  logic [IDW-1:0]  w_arb_ptr;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [IDW-1:0]  w_sel;
  logic            w_any;
  logic            w_hs;

  state_t          r_state;
  logic            r_valid;
  logic [IDW-1:0]  r_evt_id;
  logic [IDW-1:0]  r_ptr;

  assign w_rst_n = ~rst;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    bit_sync u_bit_sync (
      .clk   (clk),
      .rst_n (w_rst_n),
      .d     (async_in[g]),
      .q     (w_s[g])
    );
  end

  assign w_hs      = r_valid & evt_ready;
  assign w_id_mask = {{(N_CH-1){1'b0}}, 1'b1} << r_evt_id;
  assign w_ptr_nxt = (r_evt_id == IDW'(N_CH - 1)) ? '0 : r_evt_id + IDW'(1);

  // A rise landing on the same cycle as the handshake re-arms the channel
  // instead of counting as an overflow; disabling never aborts the live offer.
  always_comb begin
    w_rise      = w_s & ~r_s_d & en;
    w_clr       = w_hs ? w_id_mask : '0;
    w_offered   = r_valid ? w_id_mask : '0;
    w_pending_d = w_rise | (r_pending & ~w_clr & (en | w_offered));
    w_ovf_d     = (w_rise & r_pending & ~w_clr) | (r_ovf & ~{N_CH{ovf_clr}});
  end

  // In OFFER the arbiter already looks ahead past the current grant.
  always_comb begin
    w_arb_req = r_pending & en;
    w_arb_ptr = r_ptr;
    if (r_state == ST_OFFER) begin
      w_arb_req = r_pending & en & ~w_id_mask;
      w_arb_ptr = w_ptr_nxt;
    end
  end

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_rr_arbiter (
    .req (w_arb_req),
    .ptr (w_arb_ptr),
    .sel (w_sel),
    .any (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_d     <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
    end else begin
      r_s_d     <= w_s;
      r_pending <= w_pending_d;
      r_ovf     <= w_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_evt_id <= '0;
      r_ptr    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_evt_id <= w_sel;
            r_valid  <= 1'b1;
            r_state  <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (w_hs) begin
            r_ptr <= w_ptr_nxt;
            if (w_any) begin
              r_evt_id <= w_sel;
            end else begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = r_valid;
  assign evt_id    = r_evt_id;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Bench for sync_event_arbiter: per-cycle reference model plus directed
// scenarios with hand-computed event sequences and timing.
module tb_sync_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] async_in;
  logic [N-1:0] en;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_id;
  logic [N-1:0] ovf;
  logic         ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  sync_event_arbiter #(
    .N_CH (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .async_in  (async_in),
    .en        (en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: synchroniser stages, pending/overflow bits and the offer
  // as seen at the port, advanced once per clock edge.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_sd = '0, m_pend = '0, m_ovf = '0;
  int           m_valid = 0, m_id = 0, m_ptr = 0;

  function automatic int first_from(input int start, input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] rise, op, take, req;
    int hs, ov, ovid, f;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_sd = '0; m_pend = '0; m_ovf = '0;
      m_valid = 0; m_id = 0; m_ptr = 0;
    end else begin
      hs   = (m_valid != 0 && evt_ready) ? 1 : 0;
      ov   = m_valid;
      ovid = m_id;
      op   = m_pend;
      rise = m_s2 & ~m_sd & en;
      take = '0;
      if (hs != 0) take[ovid] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (rise[i] && op[i] && !take[i]) m_ovf[i] = 1'b1;
        else if (ovf_clr) m_ovf[i] = 1'b0;
        if (rise[i]) m_pend[i] = 1'b1;
        else if (take[i]) m_pend[i] = 1'b0;
        else if (!en[i] && !(ov != 0 && ovid == i)) m_pend[i] = 1'b0;
      end
      req = op & en;
      if (ov == 0) begin
        f = first_from(m_ptr, req);
        if (f >= 0) begin m_valid = 1; m_id = f; end
      end else if (hs != 0) begin
        m_ptr = (ovid + 1) % N;
        req[ovid] = 1'b0;
        f = first_from(m_ptr, req);
        if (f >= 0) m_id = f;
        else m_valid = 0;
      end
      m_sd = m_s2;
      m_s2 = m_s1;
      m_s1 = async_in;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_valid", int'(evt_valid), m_valid);
    if (m_valid != 0) chk("model_id", int'(evt_id), m_id);
    chk("model_ovf", int'(ovf), int'(m_ovf));
  end

  // Accepted-event log with cycle stamps, used by the directed scenarios.
  int log_id[$];
  int log_cyc[$];
  int lcyc = 0;
  always @(posedge clk) begin
    lcyc++;
    if (!rst && evt_valid && evt_ready) begin
      log_id.push_back(int'(evt_id));
      log_cyc.push_back(lcyc);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    log_id.delete();
    log_cyc.delete();
  endtask

  task automatic chk_log(input string name, input int exp[$], input int b2b);
    chk({name, "_count"}, log_id.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk({name, "_id"}, (i < log_id.size()) ? log_id[i] : -1, exp[i]);
      if (b2b != 0 && i > 0 && i < log_cyc.size())
        chk({name, "_b2b"}, log_cyc[i] - log_cyc[i-1], 1);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  task automatic pulse(input int ch);
    @(negedge clk);
    async_in[ch] = 1'b1;
    cycles(3);
    async_in[ch] = 1'b0;
    cycles(3);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(posedge clk); #1;
      if (evt_valid) break;
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: evt_valid not seen within %0d cycles", name, budget);
    end
  endtask

  initial begin
    rst = 1'b1; async_in = 4'hF; en = 4'hF; evt_ready = 1'b1; ovf_clr = 1'b0;

    // Reset with all lines high, then one event per channel after release.
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id", int'(evt_id), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    clear_log();
    rst = 1'b0;
    cycles(12);
    chk_log("rst_release", '{0, 1, 2, 3}, 1);

    // Single event: exact four-edge latency and a single-cycle offer.
    async_in = '0;
    cycles(5);
    clear_log();
    async_in[2] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("single_early", int'(evt_valid), 0);
    @(posedge clk); #1;
    chk("single_valid", int'(evt_valid), 1);
    chk("single_id", int'(evt_id), 2);
    @(posedge clk); #1;
    chk("single_drop", int'(evt_valid), 0);
    cycles(8);
    chk_log("single", '{2}, 0);
    async_in = '0;
    cycles(4);

    // Simultaneous rises from ptr=0.
    do_reset(2);
    clear_log();
    async_in = 4'b1011;
    cycles(10);
    chk_log("simul", '{0, 1, 3}, 1);
    async_in = '0;
    cycles(4);

    // Round-robin: after granting 2, channel 3 goes ahead of channel 0.
    do_reset(2);
    clear_log();
    evt_ready = 1'b0;
    async_in[2] = 1'b1;
    wait_valid("rr_wait", 10);
    @(negedge clk);
    async_in = 4'b1101;
    cycles(5);
    evt_ready = 1'b1;
    cycles(6);
    chk_log("rr", '{2, 3, 0}, 1);
    async_in = '0;
    cycles(4);

    // Backpressure keeps the offer stable; a repeat pulse overflows.
    do_reset(2);
    clear_log();
    evt_ready = 1'b0;
    pulse(1);
    wait_valid("bp_wait", 10);
    chk("bp_id", int'(evt_id), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", int'(evt_valid), 1);
      chk("bp_hold_id", int'(evt_id), 1);
    end
    pulse(1);
    chk("ovf_set", int'(ovf), 2);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(posedge clk); #1;
    chk("ovf_clr", int'(ovf), 0);
    @(negedge clk);
    evt_ready = 1'b1;
    cycles(6);
    chk_log("bp", '{1}, 0);

    // Masked channel produces nothing.
    clear_log();
    en = 4'b1101;
    pulse(1);
    cycles(6);
    chk_log("mask", '{}, 0);
    en = 4'hF;

    // Reset during an offer discards the event.
    evt_ready = 1'b0;
    pulse(0);
    wait_valid("rst_mid_wait", 10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", int'(evt_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    evt_ready = 1'b1;
    clear_log();
    cycles(10);
    chk_log("rst_mid", '{}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
